turn_timer_fsm: RTL and testbench

- Battleship turn controller that sits directly downstream of up_counter and consumes its 4-bit count as the per-turn timer.
- Drives up_counter's active-low reset to restart the timer at the start of each turn.
- Accepts a player "fire" button, decides whether each turn ends by a shot or by a timeout, and alternates players.
- After MAX_TURNS turns it asserts game_over.

---
 rtl/turn_timer_fsm_pkg.sv | 21 ++
 rtl/turn_timer_fsm_if.sv | 23 ++
 rtl/turn_timer_fsm_rise_detect.sv | 20 ++
 rtl/up_counter.sv | 15 +
 rtl/turn_timer_fsm.sv | 93 +++++++++
 tb/tb_turn_timer_fsm.sv | 220 ++++++++++++++++++++++
 6 files changed

// File: rtl/turn_timer_fsm_pkg.sv
// Shared types and defaults for the battleship turn controller.
// Keeps the state encoding in one place so other game blocks can decode it.
package turn_timer_fsm_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StArm    = 3'd1,
        StRun    = 3'd2,
        StSwitch = 3'd3,
        StDone   = 3'd4
    } state_e;

    localparam logic [3:0] DefaultTimeout  = 4'd12;
    localparam logic [7:0] DefaultMaxTurns = 8'd8;

    // Next turn index, used for the end-of-game decision in SWITCH.
    function automatic logic [7:0] next_turn(input logic [7:0] turns);
        return turns + 8'd1;
    endfunction

endpackage

// File: rtl/turn_timer_fsm_if.sv
// Game-side signal bundle of the turn controller.
// The master drives start/fire/count (player and timer side); the slave is the controller.
interface turn_timer_fsm_if;
    logic       start;
    logic       fire;
    logic [3:0] count;
    logic       cnt_rst;
    logic       player;
    logic       shot_valid;
    logic       timeout;
    logic [7:0] turns;
    logic       game_over;

    modport master (
        output start, fire, count,
        input  cnt_rst, player, shot_valid, timeout, turns, game_over
    );

    modport slave (
        input  start, fire, count,
        output cnt_rst, player, shot_valid, timeout, turns, game_over
    );
endinterface

// File: rtl/turn_timer_fsm_rise_detect.sv
// Rising-edge detector for a debounced button level.
// The register always tracks the input, so a held button never re-triggers.
module turn_timer_fsm_rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise
);
    logic level_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;
endmodule

// File: rtl/up_counter.sv
// Free-running 4-bit up counter with active-low asynchronous clear.
// Used as the per-turn timer feeding the turn controller.
module up_counter (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] out
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out <= 4'd0;
        end else begin
            out <= out + 4'd1;
        end
    end
endmodule

// File: rtl/turn_timer_fsm.sv
// Battleship turn controller: times each turn with an external up_counter,
// ends it on a shot or a timeout, alternates players and stops after MAX_TURNS.
module turn_timer_fsm
    import turn_timer_fsm_pkg::*;
#(
    parameter logic [3:0] TIMEOUT   = DefaultTimeout,
    parameter logic [7:0] MAX_TURNS = DefaultMaxTurns
) (
    input  logic              clk,
    input  logic              rst,
    turn_timer_fsm_if.slave   bus
);
    state_e     state_q, state_d;
    logic       player_q, player_d;
    logic [7:0] turns_q, turns_d;
    logic       fire_rise;

    turn_timer_fsm_rise_detect u_fire_rise (
        .clk   (clk),
        .rst   (rst),
        .level (bus.fire),
        .rise  (fire_rise)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            player_q <= 1'b0;
            turns_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            player_q <= player_d;
            turns_q  <= turns_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        player_d       = player_q;
        turns_d        = turns_q;
        bus.cnt_rst    = 1'b0;
        bus.shot_valid = 1'b0;
        bus.timeout    = 1'b0;
        bus.game_over  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d  = StArm;
                    turns_d  = 8'd0;
                    player_d = 1'b0;
                end
            end
            StArm: begin
                state_d = StRun;
            end
            StRun: begin
                bus.cnt_rst = 1'b1;
                // A shot in the very cycle the timer expires still counts as a shot.
                if (fire_rise) begin
                    bus.shot_valid = 1'b1;
                    state_d        = StSwitch;
                end else if (bus.count == TIMEOUT) begin
                    bus.timeout = 1'b1;
                    state_d     = StSwitch;
                end
            end
            StSwitch: begin
                turns_d = next_turn(turns_q);
                if (next_turn(turns_q) == MAX_TURNS) begin
                    state_d = StDone;
                end else begin
                    player_d = ~player_q;
                    state_d  = StArm;
                end
            end
            StDone: begin
                bus.game_over = 1'b1;
                if (bus.start) begin
                    state_d  = StArm;
                    turns_d  = 8'd0;
                    player_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.player = player_q;
    assign bus.turns  = turns_q;
endmodule

// File: tb/tb_turn_timer_fsm.sv
// Randomised bench for turn_timer_fsm with the real up_counter as its timer;
// a game-level model predicts every output on each falling clock edge.
module tb_turn_timer_fsm;
    localparam int TO  = 12;
    localparam int MAX = 8;

    logic clk;
    logic rst;

    turn_timer_fsm_if tif ();

    turn_timer_fsm #(
        .TIMEOUT   (4'd12),
        .MAX_TURNS (8'd8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (tif.slave)
    );

    up_counter u_cnt (
        .clk (clk),
        .rst (tif.cnt_rst),
        .out (tif.count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Game model: a turn is running, a switch cycle is pending, an arm cycle is pending,
    // the game is over, or nothing is happening (idle).
    bit m_running, m_switch, m_arm, m_over;
    int m_elapsed, m_turns;
    bit m_player, m_fire_prev;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_running = 0; m_switch = 0; m_arm = 0; m_over = 0;
            m_elapsed = 0; m_turns = 0; m_player = 0; m_fire_prev = 0;
        end else begin
            if (m_switch) begin
                m_switch = 0;
                m_turns++;
                if (m_turns == MAX) m_over = 1;
                else begin
                    m_player = !m_player;
                    m_arm = 1;
                end
            end else if (m_arm) begin
                m_arm = 0;
                m_running = 1;
                m_elapsed = 0;
            end else if (m_running) begin
                if ((tif.fire && !m_fire_prev) || m_elapsed == TO) begin
                    m_running = 0;
                    m_switch = 1;
                end else begin
                    m_elapsed++;
                end
            end else if (tif.start) begin
                m_over = 0; m_turns = 0; m_player = 0; m_arm = 1;
            end
            m_fire_prev = tif.fire;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            bit shot, tmo;
            shot = m_running && tif.fire && !m_fire_prev;
            tmo  = m_running && !shot && m_elapsed == TO;
            check("shot_valid", int'(tif.shot_valid), int'(shot));
            check("timeout", int'(tif.timeout), int'(tmo));
            check("cnt_rst", int'(tif.cnt_rst), int'(m_running));
            check("count", int'(tif.count), m_running ? m_elapsed : 0);
            check("player", int'(tif.player), int'(m_player));
            check("turns", int'(tif.turns), m_turns);
            check("game_over", int'(tif.game_over), int'(m_over));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b0;
        #1;
        check("rst_cnt_rst", int'(tif.cnt_rst), 0);
        check("rst_player", int'(tif.player), 0);
        check("rst_turns", int'(tif.turns), 0);
        check("rst_game_over", int'(tif.game_over), 0);
        check("rst_shot", int'(tif.shot_valid), 0);
        check("rst_count", int'(tif.count), 0);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic rand_drive();
        if ($urandom_range(0, 5) == 0) tif.fire = ~tif.fire;
        tif.start = ($urandom_range(0, 30) == 0);
    endtask

    initial begin
        int k;
        rst = 1'b0;
        tif.start = 1'b0;
        tif.fire  = 1'b0;
        #1;
        check("init_cnt_rst", int'(tif.cnt_rst), 0);
        check("init_player", int'(tif.player), 0);
        check("init_turns", int'(tif.turns), 0);
        check("init_game_over", int'(tif.game_over), 0);
        step(2);
        rst = 1'b1;
        step(1);

        // Timed-out turn.
        tif.start = 1'b1;
        step(1);
        tif.start = 1'b0;
        step(1);
        k = 0;
        while (!tif.timeout && k < 40) begin
            step(1);
            k++;
        end
        check("to_run_cycles", k, 12);
        check("to_count", int'(tif.count), 12);
        step(2);
        check("to_turns", int'(tif.turns), 1);
        check("to_player", int'(tif.player), 1);
        step(1);

        // Shot at count 5.
        step(5);
        tif.fire = 1'b1;
        #1;
        check("shot_pulse", int'(tif.shot_valid), 1);
        check("shot_count", int'(tif.count), 5);
        check("shot_no_to", int'(tif.timeout), 0);
        step(3);
        check("shot_turns", int'(tif.turns), 2);
        check("shot_player", int'(tif.player), 0);
        check("shot_new_count", int'(tif.count), 0);

        // Fire held into the next turn does not shoot.
        step(4);
        check("held_no_shot", int'(tif.shot_valid), 0);
        tif.fire = 1'b0;
        step(1);
        tif.fire = 1'b1;
        #1;
        check("reshot_pulse", int'(tif.shot_valid), 1);
        step(1);
        tif.fire = 1'b0;
        step(1);
        tif.fire = 1'b1;
        step(1);
        check("arm_edge_ignored", int'(tif.shot_valid), 0);
        tif.fire = 1'b0;

        // Fire rising exactly at the timeout count.
        step(12);
        tif.fire = 1'b1;
        #1;
        check("tie_count", int'(tif.count), 12);
        check("tie_shot", int'(tif.shot_valid), 1);
        check("tie_no_to", int'(tif.timeout), 0);
        tif.fire = 1'b0;

        // Random play to the end of the game.
        k = 0;
        while (!tif.game_over && k < 3000) begin
            rand_drive();
            tif.start = 1'b0;
            step(1);
            k++;
        end
        check("game_over_reached", int'(tif.game_over), 1);
        check("final_turns", int'(tif.turns), 8);
        check("final_player", int'(tif.player), 1);
        check("final_cnt_rst", int'(tif.cnt_rst), 0);
        step(3);
        check("done_hold_turns", int'(tif.turns), 8);
        tif.start = 1'b1;
        step(1);
        tif.start = 1'b0;
        check("restart_turns", int'(tif.turns), 0);
        check("restart_player", int'(tif.player), 0);
        check("restart_game_over", int'(tif.game_over), 0);

        // Reset while a turn is running.
        step(3);
        check("in_run_before_reset", int'(tif.cnt_rst), 1);
        pulse_reset();

        // Long random run with occasional starts and resets.
        for (int i = 0; i < 4000; i++) begin
            rand_drive();
            step(1);
            if ($urandom_range(0, 400) == 0) pulse_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
